dmem_responder: RTL and testbench

Data-memory responder for the DLX pipeline's load/store port. It accepts word read and write requests from the pipeline over a req/ack handshake and inserts a configurable number of wait states. Misaligned and out-of-range accesses are flagged with an error response. It replaces the zero-latency RAM so the pipeline's stall logic can be exercised against a realistic memory.

---
 rtl/dlx_mem_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the DLX data-memory responder.
package dlx_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [WORD_W-1:0] data;
  } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the DLX pipeline (master) and the data memory (slave).
interface dmem_responder_if;

  logic                            req_i;
  logic                            we_i;
  logic [dlx_mem_pkg::ADDR_W-1:0]  adr_i;
  logic [dlx_mem_pkg::WORD_W-1:0]  data_i;
  logic [dlx_mem_pkg::WORD_W-1:0]  data_o;
  logic                            ack_o;
  logic                            err_o;
  logic                            busy_o;
  logic [dlx_mem_pkg::ADDR_W-1:0]  mem_addr_in_use;
  logic [dlx_mem_pkg::WORD_W-1:0]  mem_addr_in_use_value;

  modport master (
    output req_i, we_i, adr_i, data_i,
    input  data_o, ack_o, err_o, busy_o, mem_addr_in_use, mem_addr_in_use_value
  );

  modport slave (
    input  req_i, we_i, adr_i, data_i,
    output data_o, ack_o, err_o, busy_o, mem_addr_in_use, mem_addr_in_use_value
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage, no reset; written on the clock edge, read through the index.
module dmem_array
  import dlx_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake with configurable wait states and error responses.
module dmem_responder
  import dlx_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  dbg_adr_q, dbg_adr_d;
  logic [WORD_W-1:0]  dbg_dat_q, dbg_dat_d;

  req_t               cur_c;
  logic               bad_c;
  logic               commit_c;
  logic               arr_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [WORD_W-1:0]  arr_rdata;

  // In IDLE the live request is used directly (zero-wait commit); afterwards the latched copy.
  always_comb begin
    cur_c = (state_q == ST_IDLE) ? '{we: bus.we_i, adr: bus.adr_i, data: bus.data_i} : req_q;
    bad_c = ((cur_c.adr & ALIGN_MASK) != '0) || ((cur_c.adr >> (IDX_W + 2)) != '0);
    idx_c = IDX_W'(cur_c.adr >> 2);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    dbg_adr_d = dbg_adr_q;
    dbg_dat_d = dbg_dat_q;
    commit_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          req_d = cur_c;
          if (bad_c) begin
            state_d = ST_ERR;
          end else if (WAIT_CYCLES == 0) begin
            state_d  = ST_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_RESP;
          commit_c = 1'b1;
        end
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    if (commit_c) begin
      if (cur_c.we) begin
        dbg_adr_d = cur_c.adr;
        dbg_dat_d = cur_c.data;
      end else begin
        rdata_d = arr_rdata;
      end
    end

    ack_d  = (state_d == ST_RESP) || (state_d == ST_ERR);
    err_d  = (state_d == ST_ERR);
    busy_d = (state_d != ST_IDLE);
  end

  // Array has no reset, so an asserted reset must block the commit write itself.
  assign arr_we_c = commit_c & cur_c.we & ~reset_i;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clock_i),
    .we    (arr_we_c),
    .idx   (idx_c),
    .wdata (cur_c.data),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      dbg_adr_q <= '0;
      dbg_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      dbg_adr_q <= dbg_adr_d;
      dbg_dat_q <= dbg_dat_d;
    end
  end

  assign bus.data_o                = rdata_q;
  assign bus.ack_o                 = ack_q;
  assign bus.err_o                 = err_q;
  assign bus.busy_o                = busy_q;
  assign bus.mem_addr_in_use       = dbg_adr_q;
  assign bus.mem_addr_in_use_value = dbg_dat_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with DEPTH_WORDS=256, WAIT_CYCLES=2.
module tb_dmem_responder;

  logic clock_i;
  logic reset_i;
  int   n_tests;
  int   n_fail;
  int   cyc;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                     input logic [31:0] data, input logic exp_err, input int exp_lat,
                     input logic [31:0] exp_rd);
    int  k;
    logic seen;
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.adr_i  = adr;
    bus.data_i = data;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clock_i);
      k++;
      if (k == 1) check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
      if (bus.ack_o) seen = 1'b1;
    end
    check({tag, "_ack"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_err"}, 32'(bus.err_o), 32'(exp_err));
    check({tag, "_data"}, bus.data_o, exp_rd);
    bus.req_i = 1'b0;
    @(negedge clock_i);
    check({tag, "_pulse"}, 32'(bus.ack_o), 32'd0);
  endtask

  initial begin
    int          acks;
    int          ack_cyc [3];
    logic [31:0] ack_err;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.adr_i  = '0;
    bus.data_i = '0;
    reset_i    = 1'b1;

    repeat (2) @(negedge clock_i);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_dbg_adr", bus.mem_addr_in_use, 32'd0);
    check("rst_dbg_val", bus.mem_addr_in_use_value, 32'd0);
    reset_i = 1'b0;
    @(negedge clock_i);

    // Basic write then read-back.
    txn("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 3, 32'h0);
    check("wr10_dbg_adr", bus.mem_addr_in_use, 32'h10);
    check("wr10_dbg_val", bus.mem_addr_in_use_value, 32'hDEAD_BEEF);
    txn("rd10", 1'b0, 32'h10, 32'h0, 1'b0, 3, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a cycle while busy.
    bus.req_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = 32'h10;
    @(posedge clock_i);
    #3 reset_i = 1'b1;
    #1;
    check("arst_ack", 32'(bus.ack_o), 32'd0);
    check("arst_busy", 32'(bus.busy_o), 32'd0);
    check("arst_data", bus.data_o, 32'd0);
    check("arst_dbg_adr", bus.mem_addr_in_use, 32'd0);
    check("arst_dbg_val", bus.mem_addr_in_use_value, 32'd0);
    @(negedge clock_i);
    reset_i   = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clock_i);
    check("arst_busy_after", 32'(bus.busy_o), 32'd0);

    txn("wr10b", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 3, 32'h0);
    txn("rd10b", 1'b0, 32'h10, 32'h0, 1'b0, 3, 32'hDEAD_BEEF);

    // Misaligned read: immediate error, state untouched.
    txn("mis12", 1'b0, 32'h12, 32'h0, 1'b1, 1, 32'hDEAD_BEEF);
    check("mis12_dbg_adr", bus.mem_addr_in_use, 32'h10);
    check("mis12_dbg_val", bus.mem_addr_in_use_value, 32'hDEAD_BEEF);

    // Out-of-range write must not alias onto word 0.
    txn("wr00", 1'b1, 32'h0, 32'h5555_5555, 1'b0, 3, 32'hDEAD_BEEF);
    txn("oor400", 1'b1, 32'h400, 32'hBAD0_BAD0, 1'b1, 1, 32'hDEAD_BEEF);
    check("oor_dbg_adr", bus.mem_addr_in_use, 32'h0);
    check("oor_dbg_val", bus.mem_addr_in_use_value, 32'h5555_5555);
    txn("rd00", 1'b0, 32'h0, 32'h0, 1'b0, 3, 32'h5555_5555);

    // Held request across three back-to-back writes.
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.adr_i  = 32'h0;
    bus.data_i = 32'd1;
    acks    = 0;
    ack_err = '0;
    for (int i = 0; i < 40 && acks < 3; i++) begin
      @(negedge clock_i);
      if (bus.ack_o) begin
        ack_cyc[acks] = cyc;
        ack_err[acks] = bus.err_o;
        acks++;
        if (acks < 3) begin
          bus.adr_i  = 32'(4 * acks);
          bus.data_i = 32'(acks + 1);
        end else begin
          bus.req_i = 1'b0;
        end
      end
    end
    check("b2b_acks", 32'(acks), 32'd3);
    check("b2b_err", ack_err, 32'd0);
    check("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
    check("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd4);
    @(negedge clock_i);
    txn("rd_b0", 1'b0, 32'h0, 32'h0, 1'b0, 3, 32'd1);
    txn("rd_b4", 1'b0, 32'h4, 32'h0, 1'b0, 3, 32'd2);
    txn("rd_b8", 1'b0, 32'h8, 32'h0, 1'b0, 3, 32'd3);

    // Reset during WAIT aborts the second write.
    txn("wr20", 1'b1, 32'h20, 32'h1111_1111, 1'b0, 3, 32'd3);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.adr_i  = 32'h20;
    bus.data_i = 32'h2222_2222;
    @(negedge clock_i);
    check("abort_busy", 32'(bus.busy_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i   = 1'b0;
    bus.req_i = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clock_i);
      if (bus.ack_o) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_dbg_val", bus.mem_addr_in_use_value, 32'd0);
    txn("rd20", 1'b0, 32'h20, 32'h0, 1'b0, 3, 32'h1111_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
